// File: rtl/reg_file_mp_if.sv
// Bus bundle for the multi-port register file: read ports, write-back port
// and the init-busy flag. The master is the datapath; the slave is the file.
interface reg_file_mp_if #(
    parameter int WIDTH    = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_READ = 2
);
    logic [NUM_READ*ADDR_W-1:0] rd_addr;
    logic [NUM_READ*WIDTH-1:0]  rd_data;
    logic                       wr_en;
    logic [ADDR_W-1:0]          wr_addr;
    logic [WIDTH-1:0]           wr_data;
    logic                       busy;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data,
        input  rd_data, busy
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data,
        output rd_data, busy
    );
endinterface

// File: rtl/reg_file_mp.sv
// Parametrised multi-port register file for the pipelined MIPS decode stage.
// NUM_READ registered read ports with write-first bypass from the single
// write-back port, optional hardwired zero register, and a reset-driven init
// sequencer that loads every entry before the file reports not-busy.
module reg_file_mp #(
    parameter int WIDTH     = 32,
    parameter int ADDR_W    = 5,
    parameter int NUM_READ  = 2,
    parameter int ZERO_REG  = 1,
    parameter int INIT_MODE = 1
) (
    input  logic         clk,
    input  logic         reset,
    reg_file_mp_if.slave bus
);
    localparam int                DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    // Control state and registered outputs
    state_t                    state_q;
    logic [ADDR_W-1:0]         cnt_q;
    logic                      busy_q;
    logic [NUM_READ*WIDTH-1:0] rd_data_q;

    // Storage array; only the sequencer and the write port modify it
    logic [WIDTH-1:0] mem_q [DEPTH];

    // Single physical write port shared by the sequencer and write-back
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [WIDTH-1:0]  mem_wdata;
    logic [WIDTH-1:0]  init_value;
    logic              wr_accept;

    // Per-port next read data (ZERO_REG, then bypass, then array)
    logic [WIDTH-1:0] rd_next [NUM_READ];

    assign init_value = (INIT_MODE != 0) ? WIDTH'(cnt_q) : '0;

    // A write to entry 0 is dropped when entry 0 is hardwired to zero
    assign wr_accept = bus.wr_en && !((ZERO_REG != 0) && (bus.wr_addr == '0));

    // Select who owns the array write port this cycle
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        mem_we    = 1'b0;
        mem_waddr = bus.wr_addr;
        mem_wdata = bus.wr_data;
        if (!reset) begin
            if (state_q == ST_INIT) begin
                mem_we    = 1'b1;
                mem_waddr = cnt_q;
                mem_wdata = init_value;
            end else if (wr_accept) begin
                mem_we = 1'b1;
            end
        end
    end

    // Per-port read mux with write-first bypass
    for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
        logic [ADDR_W-1:0] addr;

        assign addr = bus.rd_addr[k*ADDR_W +: ADDR_W];

        // Zero register wins over bypass, so a dropped write to 0 never leaks
        always_comb begin
            if ((ZERO_REG != 0) && (addr == '0)) begin
                rd_next[k] = '0;
            end else if (bus.wr_en && (bus.wr_addr == addr)) begin
                rd_next[k] = bus.wr_data;
            end else begin
                rd_next[k] = mem_q[addr];
            end
        end
    end

    // Init/run FSM with registered busy and read data
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (reset) begin
            state_q   <= ST_INIT;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            rd_data_q <= '0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    cnt_q     <= cnt_q + 1'b1;
                    rd_data_q <= '0;
                    if (cnt_q == LAST_ADDR) begin
                        state_q <= ST_RUN;
                        busy_q  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    for (int k = 0; k < NUM_READ; k++) begin
                        rd_data_q[k*WIDTH +: WIDTH] <= rd_next[k];
                    end
                end
                default: begin
                    state_q <= ST_INIT;
                    cnt_q   <= '0;
                    busy_q  <= 1'b1;
                end
            endcase
        end
    end

    // Array write; contents survive reset and are rebuilt by the sequencer
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset branch on purpose: a per-entry reset
        // would prevent RAM inference, and the init sequencer loads it anyway.
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign bus.rd_data = rd_data_q;
    assign bus.busy    = busy_q;
endmodule
